// File: rtl/frq_period_meter.sv
// ============================================================================
// Module   : frq_period_meter
// Brief    : Measures period and high time of an asynchronous square wave in
//            clk cycles, with a per-period valid strobe and stall timeout.
//            Optional macro LOG2_DECODE_EN enables the sel_code log2 decoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frq_period_meter #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout,
    output logic             busy,
    output logic [4:0]       sel_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [SYNC_STAGES-1:0]   sync_ff;
    logic                     s_lvl;
    logic                     s_lvl_d;
    logic                     rise;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         hcnt;
    logic [CNT_W-1:0]         hcnt_inc;

    // ------------------------------------------------------------------
    // Input synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= '0;
            s_lvl_d <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
            s_lvl_d <= s_lvl;
        end
    end

    assign s_lvl    = sync_ff[SYNC_STAGES-1];
    assign rise     = s_lvl & ~s_lvl_d;
    assign hcnt_inc = hcnt + {{(CNT_W-1){1'b0}}, s_lvl};

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state == ARM) || (state == MEASURE);
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (rise) state_nxt = MEASURE;
                MEASURE: if (!rise && (cnt == CNT_MAX)) state_nxt = TIMEOUT;
                TIMEOUT: if (rise) state_nxt = MEASURE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            hcnt         <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                // A rise coinciding with the enable drop is discarded here.
                cnt     <= '0;
                hcnt    <= '0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    ARM, TIMEOUT: begin
                        if (rise) begin
                            cnt     <= '0;
                            hcnt    <= CNT_ONE;
                            timeout <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period       <= (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
                            high_time    <= hcnt;
                            period_valid <= 1'b1;
                            cnt          <= '0;
                            hcnt         <= CNT_ONE;
                        end else begin
                            if (cnt != CNT_MAX) begin
                                cnt <= cnt + CNT_ONE;
                            end else begin
                                timeout <= 1'b1;
                            end
                            if (hcnt != CNT_MAX) begin
                                hcnt <= hcnt_inc;
                            end
                        end
                    end
                    default: begin
                        cnt  <= '0;
                        hcnt <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional floor(log2(period)) decoder
    // ------------------------------------------------------------------
`ifdef LOG2_DECODE_EN
    always_comb begin
        sel_code = 5'd0;
        for (int i = 0; (i < CNT_W) && (i < 32); i++) begin
            if (period[i]) begin
                sel_code = i[4:0];
            end
        end
    end
`else
    assign sel_code = 5'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frq_period_meter.sv
// ============================================================================
// Module   : tb_frq_period_meter
// Brief    : Directed self-checking bench for frq_period_meter (CNT_W = 8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frq_period_meter;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             timeout;
    logic             busy;
    logic [4:0]       sel_code;

    int checks;
    int errors;
    int cyc;
    int strobe_cnt;
    int last_strobe_cyc;
    int strobe_gap;
    int strobe_base;
    logic busy_dropped;

    frq_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sig_in       (sig_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .timeout      (timeout),
        .busy         (busy),
        .sel_code     (sel_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe and busy observer, sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset && period_valid) begin
            strobe_cnt      = strobe_cnt + 1;
            strobe_gap      = cyc - last_strobe_cyc;
            last_strobe_cyc = cyc;
        end
        if (!busy) busy_dropped = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sel_exp(input logic [31:0] v);
`ifdef LOG2_DECODE_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic wave(input int p, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            sig_in = 1'b1;
            repeat (h) @(negedge clk);
            sig_in = 1'b0;
            repeat (p - h) @(negedge clk);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        cyc             = 0;
        strobe_cnt      = 0;
        last_strobe_cyc = 0;
        strobe_gap      = 0;
        busy_dropped    = 1'b0;
        reset           = 1'b1;
        enable          = 1'b0;
        sig_in          = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", period_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_sel", sel_code, 0);

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_enable_busy", busy, 0);

        // 1: period 8, 50% duty
        enable = 1'b1;
        @(negedge clk);
        check("arm_busy", busy, 1);
        strobe_base = strobe_cnt;
        wave(8, 4, 4);
        check("p8_strobes", strobe_cnt - strobe_base, 3);
        check("p8_gap", strobe_gap, 8);
        check("p8_period", period, 8);
        check("p8_high", high_time, 4);
        check("p8_sel", sel_code, sel_exp(3));

        // 2: period 10, high 3, busy throughout
        busy_dropped = 1'b0;
        strobe_base  = strobe_cnt;
        wave(10, 3, 4);
        check("p10_strobes", strobe_cnt - strobe_base, 4);
        check("p10_gap", strobe_gap, 10);
        check("p10_period", period, 10);
        check("p10_high", high_time, 3);
        check("p10_busy_held", busy_dropped, 0);
        check("p10_sel", sel_code, sel_exp(3));

        // 6: log2 decode
        wave(32, 16, 3);
        check("p32_period", period, 32);
        check("p32_sel", sel_code, sel_exp(5));
        wave(48, 20, 3);
        check("p48_period", period, 48);
        check("p48_high", high_time, 20);
        check("p48_sel", sel_code, sel_exp(5));

        // 4: drop enable mid-period
        strobe_base = strobe_cnt;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("dis_busy", busy, 0);
        check("dis_period_hold", period, 48);
        check("dis_high_hold", high_time, 20);
        check("dis_no_strobe", strobe_cnt - strobe_base, 0);
        enable = 1'b1;
        @(negedge clk);
        wave(12, 6, 1);
        check("reen_one_rise_no_strobe", strobe_cnt - strobe_base, 0);
        check("reen_period_hold", period, 48);
        wave(12, 6, 1);
        check("reen_two_rises_strobe", strobe_cnt - strobe_base, 1);
        check("reen_period", period, 12);
        check("reen_high", high_time, 6);

        // 3: stall after a rise; timeout when cnt reaches 255
        wave(12, 6, 1);
        repeat (246) @(negedge clk);
        check("to_not_yet", timeout, 0);
        @(negedge clk);
        check("to_set", timeout, 1);
        check("to_period_hold", period, 12);
        check("to_busy", busy, 0);
        strobe_base = strobe_cnt;
        wave(20, 5, 1);
        check("to_clear", timeout, 0);
        check("to_restart_no_strobe", strobe_cnt - strobe_base, 0);
        wave(20, 5, 1);
        check("to_after_strobe", strobe_cnt - strobe_base, 1);
        check("to_after_period", period, 20);
        check("to_after_high", high_time, 5);

        // 5: asynchronous reset mid-measurement
        sig_in = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_period", period, 0);
        check("arst_high", high_time, 0);
        check("arst_timeout", timeout, 0);
        check("arst_busy", busy, 0);
        check("arst_sel", sel_code, 0);
        check("arst_valid", period_valid, 0);
        enable = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy, 0);
        enable = 1'b1;
        @(negedge clk);
        check("post_rst_arm", busy, 1);
        strobe_base = strobe_cnt;
        wave(16, 8, 1);
        check("post_rst_one_rise", strobe_cnt - strobe_base, 0);
        wave(16, 8, 1);
        check("post_rst_two_rises", strobe_cnt - strobe_base, 1);
        check("post_rst_period", period, 16);
        check("post_rst_high", high_time, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
